// File: rtl/led_frame_sequencer_if.sv
// Bundle of the upstream frame handshake, visualizer link, LED stream and status
// signals of the LED frame sequencer.
interface led_frame_sequencer_if #(
    parameter int LEDS    = 50,
    parameter int BIN_QTY = 12
);
    localparam int CW = $clog2(LEDS);

    logic                           frame_v;
    logic                           frame_ack;
    logic                           viz_start;
    logic                           viz_done;
    logic [BIN_QTY-1:0][23:0]       rgb_i;
    logic [BIN_QTY-1:0][CW-1:0]     counts_i;
    logic [23:0]                    led_rgb;
    logic                           led_v;
    logic                           led_rdy;
    logic                           led_last;
    logic                           busy;
    logic                           err_timeout;

    modport master (
        input  frame_v, viz_done, rgb_i, counts_i, led_rdy,
        output frame_ack, viz_start, led_rgb, led_v, led_last, busy, err_timeout
    );

    modport slave (
        output frame_v, viz_done, rgb_i, counts_i, led_rdy,
        input  frame_ack, viz_start, led_rgb, led_v, led_last, busy, err_timeout
    );
endinterface

// File: rtl/led_frame_sequencer.sv
// Turns one visualizer result (per-bin colour and LED count) into a fixed-length
// LED frame, padding with black or truncating so exactly LEDS LEDs go out.
module led_frame_sequencer #(
    parameter int LEDS      = 50,
    parameter int BIN_QTY   = 12,
    parameter int START_LEN = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    led_frame_sequencer_if.master bus
);
    localparam int CW   = $clog2(LEDS);
    localparam int EW   = $clog2(LEDS + 1);
    localparam int BW   = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
    localparam int TMAX = (TIMEOUT > START_LEN) ? TIMEOUT : START_LEN;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_LATCH  = 3'd3;
    localparam logic [2:0] S_STREAM = 3'd4;
    localparam logic [2:0] S_PAD    = 3'd5;

    localparam logic [BW-1:0] BIN_LAST    = BW'(BIN_QTY - 1);
    localparam logic [EW-1:0] LED_LAST    = EW'(LEDS - 1);
    localparam logic [TW-1:0] START_END   = TW'(START_LEN - 1);
    localparam logic [TW-1:0] TIMEOUT_END = TW'(TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [BW-1:0] bin_q, bin_d;
    logic [CW-1:0] lc_q, lc_d;
    logic [EW-1:0] em_q, em_d;
    logic          ack_q, ack_d;
    logic          start_q, start_d;
    logic          err_q, err_d;

    logic [BIN_QTY-1:0][23:0]   rgb_q;
    logic [BIN_QTY-1:0][CW-1:0] cnt_q;

    logic [CW-1:0] cur_cnt;
    logic          emit_bin;
    logic          xfer;

    assign cur_cnt  = cnt_q[bin_q];
    assign emit_bin = (state_q == S_STREAM) && (cur_cnt != '0);
    assign xfer     = bus.led_v && bus.led_rdy;

    assign bus.frame_ack   = ack_q;
    assign bus.viz_start   = start_q;
    assign bus.err_timeout = err_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.led_v       = emit_bin || (state_q == S_PAD);
    assign bus.led_rgb     = emit_bin ? rgb_q[bin_q] : 24'h000000;
    assign bus.led_last    = bus.led_v && (em_q == LED_LAST);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        bin_d   = bin_q;
        lc_d    = lc_q;
        em_d    = em_q;
        ack_d   = 1'b0;
        start_d = start_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.frame_v) begin
                    state_d = S_START;
                    ack_d   = 1'b1;
                    start_d = 1'b1;
                    tmr_d   = '0;
                end
            end
            S_START: begin
                if (tmr_q == START_END) begin
                    start_d = 1'b0;
                    state_d = S_WAIT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.viz_done) begin
                    state_d = S_LATCH;
                    tmr_d   = '0;
                end else if (tmr_q == TIMEOUT_END) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_LATCH: begin
                state_d = S_STREAM;
                bin_d   = '0;
                lc_d    = '0;
                em_d    = '0;
            end
            S_STREAM: begin
                // An empty bin spends one idle cycle before moving on.
                if (cur_cnt == '0) begin
                    if (bin_q == BIN_LAST) state_d = S_PAD;
                    else                   bin_d   = bin_q + 1'b1;
                end else if (xfer) begin
                    em_d = em_q + 1'b1;
                    if (em_q == LED_LAST) begin
                        state_d = S_IDLE;
                        em_d    = '0;
                        lc_d    = '0;
                        bin_d   = '0;
                    end else if (lc_q == cur_cnt - 1'b1) begin
                        lc_d = '0;
                        if (bin_q == BIN_LAST) state_d = S_PAD;
                        else                   bin_d   = bin_q + 1'b1;
                    end else begin
                        lc_d = lc_q + 1'b1;
                    end
                end
            end
            S_PAD: begin
                if (xfer) begin
                    em_d = em_q + 1'b1;
                    if (em_q == LED_LAST) begin
                        state_d = S_IDLE;
                        em_d    = '0;
                        bin_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            bin_q   <= '0;
            lc_q    <= '0;
            em_q    <= '0;
            ack_q   <= 1'b0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bin_q   <= bin_d;
            lc_q    <= lc_d;
            em_q    <= em_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    // Frame snapshot; output gating keeps it invisible outside STREAM, so no reset.
    always_ff @(posedge clk) begin
        if (state_q == S_LATCH) begin
            rgb_q <= bus.rgb_i;
            cnt_q <= bus.counts_i;
        end
    end
endmodule

// File: tb/tb_led_frame_sequencer.sv
// Randomized bench for led_frame_sequencer, checked against a queue-based frame model.
module tb_led_frame_sequencer;
    localparam int LEDS = 50;
    localparam int BINS = 12;
    localparam int SLEN = 2;
    localparam int TMO  = 1023;

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_frame_sequencer_if #(.LEDS(LEDS), .BIN_QTY(BINS)) bus ();

    led_frame_sequencer #(
        .LEDS(LEDS), .BIN_QTY(BINS), .START_LEN(SLEN), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [23:0] rgb_tab [BINS];
    int          cnt_tab [BINS];
    logic [23:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic new_colours();
        for (int b = 0; b < BINS; b++) rgb_tab[b] = 24'($urandom) | 24'h000001;
    endtask

    task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
        for (int b = 0; b < BINS; b++) cnt_tab[b] = 0;
        cnt_tab[0] = c0; cnt_tab[1] = c1; cnt_tab[2] = c2; cnt_tab[3] = c3;
    endtask

    // Expected frame: bins in order, cut at LEDS, then black up to LEDS.
    task automatic build_exp();
        exp_q.delete();
        for (int b = 0; b < BINS; b++)
            for (int k = 0; k < cnt_tab[b]; k++)
                if (exp_q.size() < LEDS) exp_q.push_back(rgb_tab[b]);
        while (exp_q.size() < LEDS) exp_q.push_back(24'h000000);
    endtask

    task automatic drive_viz();
        for (int b = 0; b < BINS; b++) begin
            bus.rgb_i[b]    = rgb_tab[b];
            bus.counts_i[b] = 6'(cnt_tab[b]);
        end
    endtask

    task automatic scramble_viz();
        for (int b = 0; b < BINS; b++) begin
            bus.rgb_i[b]    = 24'($urandom);
            bus.counts_i[b] = 6'($urandom);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_led_v"}, 32'(bus.led_v), 0);
        chk({tag, "_led_rgb"}, 32'(bus.led_rgb), 0);
        chk({tag, "_led_last"}, 32'(bus.led_last), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_ack"}, 32'(bus.frame_ack), 0);
        chk({tag, "_start"}, 32'(bus.viz_start), 0);
        chk({tag, "_err"}, 32'(bus.err_timeout), 0);
    endtask

    // done_dly < 0: never answer (timeout). abort_at >= 0: reset after that many LEDs.
    task automatic run_frame(input int rdy_mode, input int done_dly, input int abort_at);
        int n, idx, cyc, first_v;
        logic pv, pr, plast;
        logic [23:0] prgb;
        build_exp();
        @(negedge clk);
        bus.frame_v = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.frame_ack && n < 8);
        chk("ack_latency", 32'(n), 1);
        chk("start_with_ack", 32'(bus.viz_start), 1);
        chk("busy_start", 32'(bus.busy), 1);
        bus.frame_v = 1'b0;
        n = 1;
        @(negedge clk);
        chk("ack_pulse", 32'(bus.frame_ack), 0);
        while (bus.viz_start && n < 20) begin n++; @(negedge clk); end
        chk("start_len", 32'(n), SLEN);

        if (done_dly < 0) begin
            n = 0;
            while (!bus.err_timeout && n < TMO + 50) begin
                chk("tmo_led_v", 32'(bus.led_v), 0);
                n++;
                @(negedge clk);
            end
            chk("tmo_cycles", 32'(n), TMO);
            chk("tmo_err", 32'(bus.err_timeout), 1);
            chk("tmo_busy", 32'(bus.busy), 0);
            chk("tmo_led_v_after", 32'(bus.led_v), 0);
            return;
        end

        for (int i = 0; i < done_dly; i++) begin
            chk("wait_led_v", 32'(bus.led_v), 0);
            @(negedge clk);
        end
        drive_viz();
        bus.viz_done = 1'b1;
        @(negedge clk);
        bus.viz_done = 1'b0;
        @(negedge clk);
        scramble_viz();

        idx = 0; cyc = 2; first_v = -1; pv = 1'b0; pr = 1'b0; plast = 1'b0; prgb = '0;
        while (idx < LEDS && cyc < 800) begin
            if (abort_at >= 0 && idx == abort_at) begin
                bus.frame_v = 1'b0;
                #1 rst = 1'b1;
                #1 chk_all_zero("abort");
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("abort_idle_busy", 32'(bus.busy), 0);
                    chk("abort_idle_ack", 32'(bus.frame_ack), 0);
                end
                return;
            end
            case (rdy_mode)
                0:       bus.led_rdy = 1'b1;
                1:       bus.led_rdy = (cyc % 3 == 0);
                default: bus.led_rdy = 1'($urandom_range(0, 1));
            endcase
            bus.frame_v = 1'($urandom_range(0, 1));
            chk("busy_no_ack", 32'(bus.frame_ack), 0);
            if (first_v < 0 && bus.led_v) first_v = cyc;
            if (pv && !pr) begin
                chk("stall_v", 32'(bus.led_v), 1);
                chk("stall_rgb", 32'(bus.led_rgb), 32'(prgb));
                chk("stall_last", 32'(bus.led_last), 32'(plast));
            end
            if (bus.led_v && bus.led_rdy) begin
                chk("led_rgb", 32'(bus.led_rgb), 32'(exp_q[idx]));
                chk("led_last", 32'(bus.led_last), 32'(idx == LEDS - 1));
                idx++;
            end
            pv = bus.led_v; pr = bus.led_rdy; prgb = bus.led_rgb; plast = bus.led_last;
            @(negedge clk);
            cyc++;
        end
        bus.frame_v = 1'b0;
        chk("led_count", 32'(idx), LEDS);
        if (cnt_tab[0] != 0) chk("first_v_latency", 32'(first_v >= 0 && first_v <= 2), 1);
        chk("end_busy", 32'(bus.busy), 0);
        chk("end_led_v", 32'(bus.led_v), 0);
        @(negedge clk);
        chk("end_no_ack", 32'(bus.frame_ack), 0);
        chk("end_no_led", 32'(bus.led_v), 0);
    endtask

    initial begin
        bus.frame_v  = 1'b0;
        bus.viz_done = 1'b0;
        bus.led_rdy  = 1'b0;
        scramble_viz();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        new_colours(); set_counts(10, 20, 20, 0);
        run_frame(0, 5, -1);

        new_colours(); set_counts(5, 0, 10, 7); cnt_tab[5] = 8;
        run_frame(0, 3, -1);

        new_colours(); set_counts(40, 40, 0, 0);
        run_frame(0, 1, -1);

        new_colours(); set_counts(10, 20, 20, 0);
        run_frame(1, 2, -1);

        for (int f = 0; f < 4; f++) begin
            new_colours();
            for (int b = 0; b < BINS; b++)
                cnt_tab[b] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12));
            run_frame(2, int'($urandom_range(0, 20)), -1);
        end

        run_frame(0, -1, -1);

        new_colours(); set_counts(10, 20, 20, 0);
        run_frame(2, 4, -1);
        chk("err_sticky", 32'(bus.err_timeout), 1);

        new_colours(); set_counts(10, 20, 20, 0);
        run_frame(0, 4, 17);
        new_colours(); set_counts(7, 0, 30, 25);
        run_frame(0, 5, -1);
        chk("err_after_reset", 32'(bus.err_timeout), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/led_frame_sequencer.md
LED_FRAME_SEQUENCER -- requirements
Module: led_frame_sequencer

Interface
REQ-001 SHALL have parameter LEDS, default 50, number of LEDs per output frame.
REQ-002 SHALL have parameter BIN_QTY, default 12, number of colour bins supplied by the visualizer.
REQ-003 SHALL have parameter START_LEN, default 2, number of cycles viz_start is held high.
REQ-004 SHALL have parameter TIMEOUT, default 1023, number of cycles to wait for viz_done.
REQ-005 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port: frame_v  input  1  upstream note frame available.
REQ-008 SHALL have port: frame_ack  output  1  one-cycle pulse, frame accepted.
REQ-009 SHALL have port: viz_start  output  1  start strobe to visualizer.
REQ-010 SHALL have port: viz_done  input  1  visualizer results valid.
REQ-011 SHALL have port: rgb_i  input  BIN_QTY x 24  per-bin colour from visualizer.
REQ-012 SHALL have port: counts_i  input  BIN_QTY x $clog2(LEDS)  per-bin LED count from visualizer.
REQ-013 SHALL have port: led_rgb  output  24  colour of current LED.
REQ-014 SHALL have port: led_v  output  1  led_rgb valid.
REQ-015 SHALL have port: led_rdy  input  1  downstream LED driver ready.
REQ-016 SHALL have port: led_last  output  1  current LED is LED index LEDS-1.
REQ-017 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-018 SHALL have port: err_timeout  output  1  sticky, viz_done never arrived.

Function
REQ-019 SHALL implement FSM states IDLE, START, WAIT, LATCH, STREAM, PAD.
REQ-020 In IDLE, when frame_v is sampled high, SHALL pulse frame_ack for exactly the next cycle and enter START.
REQ-021 In START, SHALL drive viz_start high for exactly START_LEN consecutive cycles, beginning the cycle frame_ack is high, then enter WAIT.
REQ-022 In WAIT, SHALL count cycles; when viz_done is sampled high, SHALL enter LATCH; if TIMEOUT cycles elapse first, SHALL set err_timeout and return to IDLE with no LEDs emitted.
REQ-023 In LATCH, SHALL register rgb_i and counts_i into internal copies (one cycle); later input changes SHALL NOT affect the frame.
REQ-024 In STREAM, SHALL emit counts[b] LEDs of colour rgb[b] for b = 0 up to BIN_QTY-1, in order.
REQ-025 A bin with a zero count SHALL consume exactly one cycle with led_v low.
REQ-026 Transfer SHALL occur only when led_v and led_rdy are both high.
REQ-027 While led_v is high and led_rdy is low, led_rgb and led_last SHALL hold stable.
REQ-028 SHALL count emitted LEDs in a $clog2(LEDS+1)-bit counter; emission SHALL stop at LEDS transfers, truncating any remaining bin counts.
REQ-029 If all bins are exhausted with fewer than LEDS emitted, SHALL enter PAD and emit led_rgb = 24'h000000 until LEDS are transferred.
REQ-030 led_last SHALL be high exactly with the LEDS-th LED; after that transfer, SHALL return to IDLE.
REQ-031 frame_v high while busy SHALL NOT be acknowledged; it is accepted in IDLE on a later cycle.
REQ-032 First led_v SHALL rise no later than 2 cycles after viz_done is sampled high (nonzero bin 0).
REQ-033 err_timeout SHALL clear only on rst.

Reset
REQ-034 While rst is high, state SHALL be IDLE; frame_ack, viz_start, led_v, led_last, busy, and err_timeout SHALL be 0; led_rgb SHALL be 0; all counters SHALL be 0.
REQ-035 Reset asserted mid-frame SHALL abort immediately; after release, SHALL wait for a fresh frame_v.

Verification
REQ-036 Bench SHALL cover: frame_v=1, viz_done after 5 cycles, counts={10,20,20,0...}, led_rdy=1 -> 50 LEDs, exact colours per bin, led_last on the 50th, then IDLE.
REQ-037 Bench SHALL cover: counts sum=30 -> 30 bin LEDs then 20 black LEDs, led_last on the 50th.
REQ-038 Bench SHALL cover: counts={40,40,0...} -> 40 of rgb[0], 10 of rgb[1], no further LEDs.
REQ-039 Bench SHALL cover: led_rdy toggling 1-of-3 cycles -> led_rgb stable while stalled, 50 transfers total.
REQ-040 Bench SHALL cover: viz_done never asserted -> err_timeout=1 after 1023 WAIT cycles, led_v never high, busy=0 afterward.
REQ-041 Bench SHALL cover: rst pulse during STREAM at LED 17 -> all outputs 0, and a new frame streams 50 LEDs from bin 0.
